// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver
// Receives PS/2 device-to-host frames and turns them into scan-code events
// for the keyboard display path.
//   clk, rst         : system clock, synchronous active-high reset
//   ps2_clk/ps2_data : raw asynchronous PS/2 lines
//   code             : scan code of the last event, held between events
//   code_valid       : one-cycle strobe marking a new event on code/released/extended
//   released         : event was preceded by an F0 prefix
//   extended         : event was preceded by an E0 prefix
//   parity_err       : one-cycle strobe, frame dropped for bad odd parity
//   frame_err        : one-cycle strobe, bad stop bit or inter-bit timeout
module ps2_scan_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       released,
    output logic       extended,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clkSync_q, dataSync_q;
    logic                   clkS, dataS;
    logic                   filt_q, filt_d;
    logic [FW-1:0]          filtCnt_q, filtCnt_d;
    logic                   fe_q, fe_d;

    state_t                 state_q, state_d;
    logic [2:0]             bitCnt_q, bitCnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tout_q, tout_d;

    logic                   accept, perr, ferr;
    logic                   ext_q, ext_d, brk_q, brk_d;
    logic [7:0]             code_q, code_d;
    logic                   rel_q, rel_d, extOut_q, extOut_d;
    logic                   valid_d, perr_d, ferr_d;
    logic                   valid_q, perr_q, ferr_q;

    assign clkS  = clkSync_q[SYNC_STAGES-1];
    assign dataS = dataSync_q[SYNC_STAGES-1];

    // Glitch filter: the filtered level follows the synchronized clock only
    // after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d    = filt_q;
        filtCnt_d = '0;
        if (clkS != filt_q) begin
            if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clkS;
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
        fe_d = filt_q & ~filt_d;
    end

    // Deframer and timeout. A falling edge always beats the terminal count.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tout_d   = '0;
        accept   = 1'b0;
        perr     = 1'b0;
        ferr     = 1'b0;
        if (fe_q) begin
            unique case (state_q)
                IDLE: begin
                    if (!dataS) begin
                        state_d  = DATA;
                        bitCnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d  = {dataS, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dataS;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dataS) begin
                        ferr = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        accept = 1'b1;
                    end else begin
                        perr = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                ferr    = 1'b1;
                state_d = IDLE;
            end else begin
                tout_d = tout_q + 1'b1;
            end
        end
    end

    // Byte layer: E0/F0 only arm pending flags; any other accepted byte
    // becomes an event carrying those flags. Errors drop pending prefixes.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        code_d   = code_q;
        rel_d    = rel_q;
        extOut_d = extOut_q;
        valid_d  = 1'b0;
        perr_d   = perr;
        ferr_d   = ferr;
        if (perr || ferr) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (accept) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                code_d   = shift_q;
                rel_d    = brk_q;
                extOut_d = ext_q;
                valid_d  = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
    end

    // All state registers, including the input synchronizers.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync_q  <= '1;
            dataSync_q <= '1;
            filt_q     <= 1'b1;
            filtCnt_q  <= '0;
            fe_q       <= 1'b0;
            state_q    <= IDLE;
            bitCnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tout_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            code_q     <= 8'h00;
            rel_q      <= 1'b0;
            extOut_q   <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data};
            filt_q     <= filt_d;
            filtCnt_q  <= filtCnt_d;
            fe_q       <= fe_d;
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tout_q     <= tout_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            code_q     <= code_d;
            rel_q      <= rel_d;
            extOut_q   <= extOut_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign released   = rel_q;
    assign extended   = extOut_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: the stimulus side predicts events
// from PS/2 framing and prefix rules, a monitor checks every strobe.
module tb_ps2_scan_receiver;

    localparam int TOUT = 300;
    localparam int H    = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] code;
    logic       codeValid, released, extended, parityErr, frameErr;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;

    ev_t        expQ[$];
    int         total = 0;
    int         bad = 0;
    logic       pendExt = 1'b0, pendBrk = 1'b0;
    logic [7:0] heldCode = 8'h00;
    logic       heldRel = 1'b0, heldExt = 1'b0;

    ps2_scan_receiver #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clock), .rst(reset), .ps2_clk(ps2Clk), .ps2_data(ps2Data),
        .code(code), .code_valid(codeValid), .released(released),
        .extended(extended), .parity_err(parityErr), .frame_err(frameErr)
    );

    always #5 clock = ~clock;

    // Reference model: one full frame's effect on events and pending prefixes.
    task automatic modelFrame(input logic [7:0] b, input logic parBad, input logic stopBit);
        ev_t e;
        e.code = b; e.rel = 1'b0; e.ext = 1'b0;
        if (!stopBit) begin
            e.kind = 2; expQ.push_back(e); pendExt = 0; pendBrk = 0;
        end else if (parBad) begin
            e.kind = 1; expQ.push_back(e); pendExt = 0; pendBrk = 0;
        end else if (b == 8'hE0) begin
            pendExt = 1'b1;
        end else if (b == 8'hF0) begin
            pendBrk = 1'b1;
        end else begin
            e.kind = 0; e.rel = pendBrk; e.ext = pendExt; expQ.push_back(e);
            heldCode = b; heldRel = pendBrk; heldExt = pendExt;
            pendExt = 0; pendBrk = 0;
        end
    endtask

    task automatic sendBit(input logic v, input logic glitch);
        ps2Data = v;
        if (glitch) begin
            repeat (4) @(posedge clock);
            ps2Clk = 1'b0;
            repeat (2) @(posedge clock);
            ps2Clk = 1'b1;
            repeat (H - 6) @(posedge clock);
        end else begin
            repeat (H) @(posedge clock);
        end
        ps2Clk = 1'b0;
        repeat (H) @(posedge clock);
        ps2Clk = 1'b1;
    endtask

    task automatic gap();
        ps2Data = 1'b1;
        repeat (3 * H) @(posedge clock);
    endtask

    task automatic checkOutput(input string name);
        @(negedge clock);
        total++;
        if (code !== heldCode || released !== heldRel || extended !== heldExt ||
            codeValid !== 1'b0 || parityErr !== 1'b0 || frameErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s: got code=%h rel=%b ext=%b v=%b pe=%b fe=%b, want code=%h rel=%b ext=%b strobes=0",
                     name, code, released, extended, codeValid, parityErr, frameErr, heldCode, heldRel, heldExt);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic parBad, input logic stopBit, input int glitchBit);
        logic [10:0] bits;
        modelFrame(b, parBad, stopBit);
        bits = {stopBit, (~^b) ^ parBad, b, 1'b0};
        for (int i = 0; i < 11; i++) sendBit(bits[i], glitchBit == i);
        gap();
    endtask

    task automatic partialFrame(input int n);
        ev_t e;
        e.kind = 2; e.code = 8'h00; e.rel = 1'b0; e.ext = 1'b0;
        expQ.push_back(e);
        pendExt = 0; pendBrk = 0;
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < n; i++) sendBit(1'($urandom_range(0, 1)), 1'b0);
        ps2Data = 1'b1;
        repeat (TOUT + 40) @(posedge clock);
    endtask

    // Monitor: pops one expectation per strobe and compares it.
    initial begin
        ev_t e;
        int  n, kind;
        forever begin
            @(negedge clock);
            n = int'(codeValid) + int'(parityErr) + int'(frameErr);
            if (n != 0) begin
                total++;
                kind = codeValid ? 0 : (parityErr ? 1 : 2);
                if (n > 1) begin
                    bad++;
                    $display("[TB] FAIL onehot: got %0d strobes, want 1", n);
                end else if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected: got strobe kind=%0d, want none", kind);
                end else begin
                    e = expQ.pop_front();
                    if (kind != e.kind || (kind == 0 &&
                        (code !== e.code || released !== e.rel || extended !== e.ext))) begin
                        bad++;
                        $display("[TB] FAIL event: got kind=%0d code=%h rel=%b ext=%b, want kind=%0d code=%h rel=%b ext=%b",
                                 kind, code, released, extended, e.kind, e.code, e.rel, e.ext);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        checkOutput("reset");

        applyStimulus(8'h1C, 0, 1, -1);  checkOutput("make_1C");
        applyStimulus(8'hF0, 0, 1, -1);  checkOutput("after_F0");
        applyStimulus(8'h1C, 0, 1, -1);  checkOutput("break_1C");
        applyStimulus(8'hE0, 0, 1, -1);
        applyStimulus(8'hF0, 0, 1, -1);
        applyStimulus(8'h75, 0, 1, -1);  checkOutput("ext_break_75");
        applyStimulus(8'h1C, 0, 1, -1);  checkOutput("plain_after_ext");
        applyStimulus(8'h1C, 1, 1, -1);  checkOutput("parity_fault");
        applyStimulus(8'hF0, 0, 1, -1);
        applyStimulus(8'h33, 1, 1, -1);
        applyStimulus(8'h1C, 0, 1, -1);  checkOutput("brk_cleared_by_perr");
        applyStimulus(8'h5A, 1, 0, -1);  checkOutput("stop_and_parity_bad");
        partialFrame(4);                 checkOutput("timeout");
        applyStimulus(8'h1C, 0, 1, -1);  checkOutput("after_timeout");
        applyStimulus(8'h29, 0, 1, 5);   checkOutput("glitch_ignored");

        applyStimulus(8'hF0, 0, 1, -1);
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        pendExt = 0; pendBrk = 0; heldCode = 8'h00; heldRel = 0; heldExt = 0;
        checkOutput("reset_mid_frame");
        gap();
        applyStimulus(8'h1C, 0, 1, -1);  checkOutput("after_reset");

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                partialFrame($urandom_range(1, 9));
            end else begin
                applyStimulus(r < 3 ? 8'hE0 : (r < 5 ? 8'hF0 : 8'($urandom_range(0, 255))),
                              $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                              $urandom_range(0, 3) == 0 ? $urandom_range(1, 9) : -1);
            end
            checkOutput("random");
        end

        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL missing_events: got %0d unconsumed, want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
PS/2 device-to-host receiver that sits directly upstream of the keyboard display path. It samples the raw ps2_clk/ps2_data lines in the system clock domain, deframes 11-bit PS/2 frames, and checks parity and stop bits. It folds E0/F0 prefixes into flags on a single scan-code event, producing a held 8-bit code plus a one-cycle valid strobe for the seven-segment decoders.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each of ps2_clk and ps2_data (minimum 2)
FILTER_LEN, 4, consecutive identical synchronized samples needed to change the filtered ps2_clk level
TIMEOUT_CYCLES, 50000, clk cycles with no filtered falling edge before an in-progress frame is aborted

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_data  input  1  raw PS/2 data line, asynchronous
code  output  8  scan code of the last accepted event; held until the next event
code_valid  output  1  one-cycle strobe; code/released/extended are valid for the new event
released  output  1  event was preceded by F0 (break)
extended  output  1  event was preceded by E0
parity_err  output  1  one-cycle strobe; frame discarded due to bad odd parity
frame_err  output  1  one-cycle strobe; bad stop bit or timeout abort

Behaviour:
- Reset, sampled on the rising clk edge while rst=1: code=0x00; all strobes and flags 0; FSM=IDLE; bit count 0; E0/F0 pending flags cleared; filtered clk=1; sync chains=1; timeout counter 0. Reset mid-frame discards the partial frame with no strobe.
- Input conditioning:
  - Both lines pass through SYNC_STAGES flops.
  - The filtered clk changes level only after FILTER_LEN consecutive equal samples. Shorter glitches are ignored.
  - A falling edge (fe) is registered when filtered clk goes 1->0.
  - Data is sampled from the synchronized ps2_data in the same cycle fe is detected.
- Deframing FSM, advancing only on fe:
  - IDLE: sampled bit 0 -> DATA with count=0. Sampled bit 1 is ignored and the FSM stays in IDLE.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: sampled bit 1 and odd parity (data ones + parity bit odd) -> byte accepted.
    - Stop bit 0 -> frame_err.
    - Stop bit 1 with bad parity -> parity_err.
    - Stop bit 0 and bad parity together -> frame_err only.
    - Always -> IDLE.
- Timeout:
  - The counter runs only while the FSM is not in IDLE and clears on every fe.
  - When it reaches TIMEOUT_CYCLES-1 without an fe: frame_err pulse, FSM -> IDLE, byte discarded.
  - If fe and the terminal count occur in the same cycle, fe wins and there is no timeout.
- Any error (parity, stop or timeout) also clears the pending E0/F0 flags.
- Byte layer, for accepted bytes:
  - 0xE0: set pending ext; no output.
  - 0xF0: set pending brk; no output.
  - Any other byte: in the next cycle, code=byte, extended=ext, released=brk, code_valid=1 for exactly one cycle. Pending flags then clear.
  - released and extended hold their values alongside code until the next event.
- Latency: code_valid asserts exactly 1 clk after the cycle in which the stop-bit fe is detected. parity_err and frame_err follow the same timing. Timeout strobes assert in the cycle after the terminal count.
- Only one strobe is ever active per cycle. Frames arriving back-to-back at PS/2 rates (>=20 us bit period) are never lost.

Test Plan:
- Make code 'A': frame 0,00111000(LSB first),p=0,stop=1 -> code_valid pulse with code=0x1C, released=0, extended=0; code holds 0x1C afterwards.
- Break sequence F0 (p=1) then 1C -> exactly one code_valid pulse, code=0x1C, released=1, extended=0; no strobe after the F0 frame.
- Extended release E0, F0, 75 (parities 0,1,0) -> single code_valid with code=0x75, extended=1, released=1; a following plain 0x1C frame reports extended=0, released=0.
- Parity fault: 0x1C frame with parity bit 1 -> parity_err pulse, no code_valid, code unchanged. F0 then a bad-parity frame then 1C -> 1C reported with released=0.
- Timeout and glitch: stop ps2_clk after 5 bits for TIMEOUT_CYCLES cycles -> frame_err pulse, FSM back in IDLE, and the next valid 0x1C frame decodes correctly. A 2-cycle low glitch on ps2_clk with FILTER_LEN=4 -> no bit consumed.
- Reset mid-frame: assert rst for 1 cycle after 4 data bits -> all outputs 0, no strobe. A subsequent full 0x1C frame -> code_valid with code=0x1C.
